// File: rtl/cpu_press_gen.sv
// CyberWar computer-opponent press generator: fires a press when the LFSR word falls
// below the difficulty threshold, then holds off for COOLDOWN cycles. Optional press statistics via CPU_PRESS_STATS_EN.
module cpu_press_gen #(
    parameter int WIDTH    = 10,
    parameter int COOLDOWN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] rnd,
    input  logic [WIDTH-1:0] threshold,
    output logic             press,
    output logic             busy,
    output logic [7:0]       press_count
);

    localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(COOLDOWN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_PRESS,
        S_COOL
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          hit;

    // Strict unsigned compare: threshold 0 never hits, all-ones misses only rnd all-ones.
    assign hit = (rnd < threshold);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (enable) state_next = S_ARMED;
            end
            S_ARMED: begin
                if (!enable)  state_next = S_IDLE;
                else if (hit) state_next = S_PRESS;
            end
            S_PRESS: begin
                if (!enable) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_COOL;
                    cnt_next   = CNT_LOAD;
                end
            end
            S_COOL: begin
                if (!enable) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    state_next = S_ARMED;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            press <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            press <= (state_next == S_PRESS);
            busy  <= (state_next == S_PRESS) || (state_next == S_COOL);
        end
    end

`ifdef CPU_PRESS_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic press_entry;
    assign press_entry = (state_next == S_PRESS) && (state != S_PRESS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_count <= 8'd0;
        end else if (press_entry) begin
            press_count <= sat_inc(press_count);
        end
    end
`else
    assign press_count = 8'd0;
`endif

endmodule
